// File: rtl/eq_pkg.sv
// -----------------------------------------------------------------------------
// eq_pkg
// Shared definitions for the sample queue that feeds the FIR band filters:
// default buffer geometry, the readout state encoding and the packed stereo
// sample type ({left, right}, 16 bits each).
// -----------------------------------------------------------------------------
package eq_pkg;

   localparam int DEFAULT_DEPTH = 1024;
   localparam int DEFAULT_TAPS  = 1021;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } state_t;

   typedef logic [31:0] stereo_t;

   // Left channel occupies the upper half of a stored entry.
   function automatic stereo_t pack_sample(input logic [15:0] lft,
                                           input logic [15:0] rght);
      return {lft, rght};
   endfunction

endpackage

// File: rtl/queue_ram.sv
// -----------------------------------------------------------------------------
// queue_ram
// Simple dual-port storage for the sample queue, written so it maps onto a
// block RAM: one write port, one registered read port, no reset on the array
// or the read register.
// Ports:
//   clk      - rising-edge clock
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - 32-bit entry to store
//   re       - read enable; rd_data updates on the next edge when high
//   rd_addr  - read address
//   rd_data  - registered read data (holds its value when re is low)
// A read and write of the same address in one cycle returns the old entry.
// -----------------------------------------------------------------------------
module queue_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic          re,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read port; non-blocking semantics give read-before-write on collisions.
   always_ff @(posedge clk) begin
      if (re) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/sample_queue.sv
// -----------------------------------------------------------------------------
// sample_queue
// Circular stereo sample buffer. Every valid sample is stored; once TAPS
// samples have been collected, each further valid (in IDLE) triggers a burst
// that replays the newest TAPS samples oldest-first to the FIR filters.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset (buffer contents kept)
//   valid      - one-cycle strobe qualifying lft_in/rght_in
//   lft_in     - signed left sample
//   rght_in    - signed right sample
//   lft_out    - replayed left sample, zero when sequencing is low
//   rght_out   - replayed right sample, zero when sequencing is low
//   sequencing - high for exactly TAPS cycles while outputs carry readout data
//   overrun    - one-cycle pulse after a valid that arrived during readout
// -----------------------------------------------------------------------------
module sample_queue
   import eq_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int TAPS  = DEFAULT_TAPS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid,
   input  logic [15:0] lft_in,
   input  logic [15:0] rght_in,
   output logic [15:0] lft_out,
   output logic [15:0] rght_out,
   output logic        sequencing,
   output logic        overrun
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TAPS + 1);

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] fill;
   logic [CW-1:0] rd_cnt;
   logic          load_rd;
   logic          rd_en;
   stereo_t       rd_data;

   queue_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we      (valid),
      .wr_addr (wr_ptr),
      .wr_data (pack_sample(lft_in, rght_in)),
      .re      (rd_en),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Trigger when this valid completes (or finds) a full window; a valid seen
   // in READ, including the last READ cycle, never starts a new burst.
   always_comb begin
      state_next = state;
      load_rd    = 1'b0;
      rd_en      = 1'b0;
      case (state)
         IDLE: begin
            if (valid && (fill >= CW'(TAPS - 1))) begin
               state_next = READ;
               load_rd    = 1'b1;
            end
         end
         READ: begin
            rd_en = 1'b1;
            if (rd_cnt == CW'(TAPS - 1)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Pointers and counters. The read pointer starts TAPS-1 entries behind the
   // slot just written, so the final read returns the triggering sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill       <= '0;
         rd_cnt     <= '0;
         sequencing <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill != CW'(TAPS)) begin
               fill <= fill + 1'b1;
            end
         end
         if (load_rd) begin
            rd_ptr <= wr_ptr - AW'(TAPS - 1);
            rd_cnt <= '0;
         end else if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_cnt <= rd_cnt + 1'b1;
         end
         sequencing <= rd_en;
         overrun    <= valid && (state == READ);
      end
   end

   assign lft_out  = sequencing ? rd_data[31:16] : 16'h0000;
   assign rght_out = sequencing ? rd_data[15:0]  : 16'h0000;

endmodule

// File: tb/tb_sample_queue.sv
// -----------------------------------------------------------------------------
// tb_sample_queue
// Self-checking bench for sample_queue. A transaction-level reference model
// keeps the full history of accepted samples and the edge on which the last
// burst was triggered; expected outputs are looked up from that history.
// -----------------------------------------------------------------------------
module tb_sample_queue;
   import eq_pkg::*;

   localparam int DEPTH = DEFAULT_DEPTH;
   localparam int TAPS  = DEFAULT_TAPS;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [15:0] lft_in = '0;
   logic [15:0] rght_in = '0;
   logic [15:0] lft_out;
   logic [15:0] rght_out;
   logic        sequencing;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   logic [31:0] hist[$];
   int          fill_m = 0;
   int          edge_n = 0;
   int          trig_edge = 0;
   int          trig_pos = 0;
   bit          trig_ok = 1'b0;
   bit          ovr_exp = 1'b0;
   bit          seq_exp = 1'b0;
   logic [31:0] data_exp = '0;
   int          run = 0;

   sample_queue #(
      .DEPTH (DEPTH),
      .TAPS  (TAPS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid      (valid),
      .lft_in     (lft_in),
      .rght_in    (rght_in),
      .lft_out    (lft_out),
      .rght_out   (rght_out),
      .sequencing (sequencing),
      .overrun    (overrun)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Single comparison point for the whole bench.
   task automatic check_output(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s at edge %0d: got %h expected %h", tag, edge_n, got, exp);
      end
   endtask

   // Reference model: advance one clock edge with the inputs seen on it.
   task automatic model_edge(input bit v, input logic [31:0] d);
      bit in_read;
      edge_n++;
      in_read = trig_ok && (edge_n >= trig_edge + 1) && (edge_n <= trig_edge + TAPS);
      ovr_exp = 1'b0;
      if (v) begin
         hist.push_back(d);
         if (fill_m < TAPS) fill_m++;
         if (in_read) begin
            ovr_exp = 1'b1;
         end else if (fill_m == TAPS) begin
            trig_ok   = 1'b1;
            trig_edge = edge_n;
            trig_pos  = hist.size() - 1;
         end
      end
      seq_exp  = trig_ok && (edge_n >= trig_edge + 1) && (edge_n <= trig_edge + TAPS);
      data_exp = seq_exp ? hist[trig_pos - TAPS + 1 + (edge_n - trig_edge - 1)] : 32'h0;
   endtask

   task automatic model_reset();
      fill_m   = 0;
      trig_ok  = 1'b0;
      ovr_exp  = 1'b0;
      seq_exp  = 1'b0;
      data_exp = '0;
      run      = 0;
   endtask

   // Per-cycle comparison plus a burst-length check when sequencing drops.
   task automatic check_cycle();
      check_output("sequencing", {31'b0, sequencing}, {31'b0, seq_exp});
      check_output("overrun", {31'b0, overrun}, {31'b0, ovr_exp});
      check_output("lft_out", {16'b0, lft_out}, {16'b0, data_exp[31:16]});
      check_output("rght_out", {16'b0, rght_out}, {16'b0, data_exp[15:0]});
      if (sequencing) begin
         run++;
      end else if (run > 0) begin
         check_output("burst_len", run, TAPS);
         run = 0;
      end
   endtask

   // Drive one cycle of input (set at the negedge), then check after the edge.
   task automatic apply_stimulus(input bit v, input logic [15:0] l,
                                 input logic [15:0] r);
      valid   = v;
      lft_in  = l;
      rght_in = r;
      @(posedge clk);
      model_edge(v, {l, r});
      @(negedge clk);
      valid = 1'b0;
      check_cycle();
   endtask

   task automatic idle(input int n);
      repeat (n) apply_stimulus(1'b0, 16'h0, 16'h0);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check_output("rst_sequencing", {31'b0, sequencing}, 32'h0);
      check_output("rst_overrun", {31'b0, overrun}, 32'h0);
      check_output("rst_lft_out", {16'b0, lft_out}, 32'h0);
      check_output("rst_rght_out", {16'b0, rght_out}, 32'h0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      $display("[TB] sample_queue bench start, DEPTH=%0d TAPS=%0d", DEPTH, TAPS);
      repeat (3) @(negedge clk);
      check_output("init_sequencing", {31'b0, sequencing}, 32'h0);
      check_output("init_overrun", {31'b0, overrun}, 32'h0);
      check_output("init_lft_out", {16'b0, lft_out}, 32'h0);
      check_output("init_rght_out", {16'b0, rght_out}, 32'h0);
      rst_n = 1'b1;

      // Fill to one short of a window: nothing may be replayed.
      for (int i = 1; i <= TAPS - 1; i++) begin
         idle($urandom_range(0, 19));
         apply_stimulus(1'b1, 16'(i), 16'(-i));
      end
      idle(5);

      // Triggering sample, an overrun 100 cycles in, then a follow-up burst.
      apply_stimulus(1'b1, 16'h1234, 16'hABCD);
      idle(100);
      apply_stimulus(1'b1, 16'h5555, 16'hAAAA);
      idle(TAPS);
      apply_stimulus(1'b1, 16'h0F0F, 16'hF0F0);
      idle(TAPS + 3);

      // Fresh run across the pointer wrap with dense random valids.
      do_reset();
      for (int n = 1; n <= 2100; n++) begin
         idle($urandom_range(0, 2));
         apply_stimulus(1'b1, 16'(n), 16'(-n));
      end
      idle(TAPS + 3);

      // Reset in the middle of a burst, then a full refill before the next.
      apply_stimulus(1'b1, 16'h7777, 16'h8888);
      idle(100);
      do_reset();
      for (int i = 1; i <= TAPS; i++) begin
         idle($urandom_range(0, 3));
         apply_stimulus(1'b1, 16'($urandom), 16'($urandom));
      end
      idle(TAPS + 3);

      // Steady state: one valid per burst, spaced so none lands in READ.
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b1, 16'($urandom), 16'($urandom));
         idle(TAPS + $urandom_range(0, 5));
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
